// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio-path types and default rate constants
package audio_pkg;

    localparam int AUDIO_FRAC_BITS = 16;
    localparam int AUDIO_OUT_DIV   = 1120;

    typedef logic signed [15:0] audio_sample_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        MUL,
        SUM
    } lerp_state_t;

endpackage

// File: rtl/audio_tick_gen.sv
// rtl/audio_tick_gen.sv - free-running divide-by-DIV counter with terminal-count tick
module audio_tick_gen #(
    parameter int DIV = 1120
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/audio_lerp_interpolator.sv
// rtl/audio_lerp_interpolator.sv - fixed-rate linear-interpolation upsampler
// Pulls input samples on phase carry and blends the two newest by the phase fraction.
module audio_lerp_interpolator
    import audio_pkg::*;
#(
    parameter int FRAC_BITS = AUDIO_FRAC_BITS,
    parameter int OUT_DIV   = AUDIO_OUT_DIV
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [FRAC_BITS-1:0] step,
    input  logic [15:0]          in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [15:0]          out_data,
    output logic                 out_valid,
    output logic                 underrun
);

    localparam int PW = FRAC_BITS + 18;
    localparam logic signed [PW-1:0] HALF =
        {{(PW - FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}};

    lerp_state_t            state;
    lerp_state_t            state_next;
    logic                   tick;
    logic                   pending;
    logic                   trigger;
    logic                   handshake;
    logic [FRAC_BITS-1:0]   phase;
    logic [FRAC_BITS:0]     phase_sum;
    audio_sample_t          s0;
    audio_sample_t          s1;
    logic signed [16:0]     diff;
    logic signed [PW-1:0]   diff_ext;
    logic signed [PW-1:0]   phase_ext;
    logic signed [PW-1:0]   prod;

    audio_tick_gen #(
        .DIV (OUT_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign trigger   = tick || pending;
    assign handshake = in_valid && in_ready;
    assign phase_sum = {1'b0, phase} + {1'b0, step};
    assign diff      = {s1[15], s1} - {s0[15], s0};
    assign diff_ext  = {{(PW - 17){diff[16]}}, diff};
    assign phase_ext = {{(PW - FRAC_BITS){1'b0}}, phase};

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (trigger) state_next = phase_sum[FRAC_BITS] ? FETCH : MUL;
            FETCH:   if (handshake || tick) state_next = MUL;
            MUL:     state_next = SUM;
            SUM:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= 1'b0;
            phase     <= '0;
            s0        <= '0;
            s1        <= '0;
            prod      <= '0;
            in_ready  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == FETCH);
            out_valid <= (state == SUM);

            if (state == IDLE) begin
                if (trigger) begin
                    phase   <= phase_sum[FRAC_BITS-1:0];
                    pending <= 1'b0;
                end
            end else if (tick) begin
                pending <= 1'b1;
            end

            // A missed deadline repeats the newest sample rather than stalling the output rate.
            if (state == FETCH) begin
                if (handshake) begin
                    s0 <= s1;
                    s1 <= in_data;
                end else if (tick) begin
                    s0       <= s1;
                    underrun <= 1'b1;
                end
            end

            if (state == MUL) begin
                prod <= diff_ext * phase_ext;
            end

            if (state == SUM) begin
                out_data <= s0 + 16'((prod + HALF) >>> FRAC_BITS);
            end
        end
    end

endmodule

// File: tb/tb_audio_lerp_interpolator.sv
// tb/tb_audio_lerp_interpolator.sv - scoreboard bench for audio_lerp_interpolator
module tb_audio_lerp_interpolator;

    localparam int FB  = 16;
    localparam int DIV = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [FB-1:0] step = '0;
    logic [15:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   out_data;
    logic          out_valid;
    logic          underrun;

    audio_lerp_interpolator #(
        .FRAC_BITS (FB),
        .OUT_DIV   (DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .step      (step),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_q[$];
    int src_q[$];
    int ir_log[$];
    int ov_count = 0;
    int ov_cyc = -1;
    bit src_en = 1'b0;
    bit rnd_mode = 1'b0;
    bit last_hs = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Cycle index since reset release: cycle 0 runs from release to the first posedge.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (in_ready) ir_log.push_back(cyc);
            if (out_valid) begin
                ov_count++;
                ov_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0d at cycle %0d, expected none",
                             int'($signed(out_data)), cyc);
                end else begin
                    check("out_data", int'($signed(out_data)), exp_q.pop_front());
                end
            end
        end
    end

    // Source: presents the head of src_q and pops it after each accepted handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (last_hs && !reset && src_q.size() > 0) void'(src_q.pop_front());
            if (rnd_mode) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 16'($urandom);
            end else begin
                in_valid = src_en && (src_q.size() > 0);
                in_data  = (src_q.size() > 0) ? 16'(src_q[0]) : 16'h0000;
            end
            last_hs = in_valid && in_ready;
        end
    end

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        ov_count = 0;
        ir_log.delete();
    endtask

    task automatic start(input logic [FB-1:0] s, input bit en);
        @(negedge clk);
        reset = 1'b1;
        step = s;
        src_en = en;
        repeat (3) @(negedge clk);
        release_reset();
    endtask

    task automatic wait_outputs(input int n, input string name);
        int budget = 400;
        while (ov_count < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check(name, int'(ov_count >= n), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs, then step = 0 latency.
        rnd_mode = 1'b1;
        repeat (6) begin
            @(negedge clk);
            step = 16'($urandom);
        end
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_underrun", int'(underrun), 0);
        step = '0;
        rnd_mode = 1'b0;
        repeat (2) @(negedge clk);
        release_reset();
        exp_q.push_back(0);
        exp_q.push_back(0);
        wait_outputs(1, "s1_first_out");
        check("s1_first_cycle", ov_cyc, 18);
        wait_outputs(2, "s1_second_out");
        check("s1_second_cycle", ov_cyc, 34);
        check("s1_no_in_ready", ir_log.size(), 0);

        // 2x upsample.
        src_q = '{1000, 2000, 3000};
        start(16'h8000, 1'b1);
        exp_q = '{0, 0, 500, 1000, 1500, 2000, 2500};
        wait_outputs(7, "s2_outputs");
        check("s2_underrun", int'(underrun), 0);
        check("s2_ir_count", ir_log.size(), 3);
        foreach (ir_log[i]) check("s2_ir_every_second_tick", ir_log[i] % 32, 0);
        check("s2_last_cycle", ov_cyc, 114);

        // Extreme span, then phase 0xFFFF over the same pair.
        src_q = '{-32768, 32767};
        start(16'h8000, 1'b1);
        exp_q = '{0, 0, -16384, -32768, 0};
        wait_outputs(5, "s3_outputs");
        step = 16'h7FFF;
        exp_q.push_back(32766);
        wait_outputs(6, "s3_top_out");
        check("s3_top_cycle", ov_cyc, 98);
        check("s3_underrun", int'(underrun), 0);

        // Underrun and recovery.
        src_q = '{1000};
        start(16'h8000, 1'b1);
        exp_q = '{0, 0, 500, 1000};
        wait_outputs(3, "s4_pre");
        check("s4_underrun_clear", int'(underrun), 0);
        wait_outputs(4, "s4_underrun_out");
        check("s4_underrun_cycle", ov_cyc, 82);
        check("s4_underrun_set", int'(underrun), 1);
        src_q.push_back(3000);
        exp_q.push_back(1000);
        exp_q.push_back(1000);
        exp_q.push_back(2000);
        wait_outputs(7, "s4_recover");
        check("s4_underrun_sticky", int'(underrun), 1);
        check("s4_refetch_cycle", ir_log[ir_log.size() - 1], 96);
        check("s4_recover_cycle", ov_cyc, 114);

        // Full-rate fetch latency.
        src_q = '{5000};
        start(16'hFFFF, 1'b1);
        exp_q = '{0, 5000};
        wait_outputs(2, "s5_outputs");
        check("s5_fetch_out_cycle", ov_cyc, 35);
        check("s5_ir_count", ir_log.size(), 1);
        if (ir_log.size() > 0) check("s5_ir_cycle", ir_log[0], 32);

        // Reset while a fetch is pending.
        begin
            int budget = 100;
            while (!in_ready && budget > 0) begin
                @(negedge clk);
                budget--;
            end
        end
        check("s6_in_fetch", int'(in_ready), 1);
        #2 reset = 1'b1;
        #1 check("s6_async_in_ready", int'(in_ready), 0);
        check("s6_async_out_valid", int'(out_valid), 0);
        step = '0;
        src_en = 1'b0;
        repeat (2) @(negedge clk);
        release_reset();
        exp_q.push_back(0);
        wait_outputs(1, "s6_first_out");
        check("s6_first_cycle", ov_cyc, 18);
        check("s6_underrun_cleared", int'(underrun), 0);
        check("s6_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
